single_port_memory: RTL and testbench

- Single-port synchronous RAM: one shared address bus, one write port, one registered read port.
- Default geometry is 1024 words x 8 bits.
- Used as a general-purpose scratch/storage block inside the datapath, clocked by the system clock.
- Storage is implemented as a register array so that reset can clear it deterministically.

---
 rtl/single_port_memory_if.sv | 24 ++
 rtl/single_port_memory.sv | 32 +++
 tb/tb_single_port_memory.sv | 132 +++++++++++++
 3 files changed

// File: rtl/single_port_memory_if.sv
// Bus bundle for single_port_memory: shared address, write port and registered read data.
interface single_port_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output write_enable,
    output write_data,
    output addr,
    input  read_data
  );

  modport slave (
    input  write_enable,
    input  write_data,
    input  addr,
    output read_data
  );
endinterface

// File: rtl/single_port_memory.sv
// Single-port RAM in a register array, 1-cycle registered read, write-first forwarding.
// Synchronous reset clears every word and the read register; reset wins over a write.
module single_port_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  single_port_memory_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;

  assign bus.read_data = r_read_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.write_enable) begin
      // write-first: the incoming word is forwarded straight to the read register
      r_mem[bus.addr] <= bus.write_data;
      r_read_data     <= bus.write_data;
    end else begin
      r_read_data <= r_mem[bus.addr];
    end
  end
endmodule

// File: tb/tb_single_port_memory.sv
// Randomised + directed bench for single_port_memory against an array reference model.
module tb_single_port_memory;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;

  single_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  single_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_rd;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, update the model, check just after
  // the edge and again mid-cycle to confirm the output holds.
  task automatic do_cycle(input logic rst, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag);
    reset            = rst;
    bus.write_enable = we;
    bus.addr         = a;
    bus.write_data   = d;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_rd = '0;
    end else if (we) begin
      ref_mem[a] = d;
      ref_rd     = d;
    end else begin
      ref_rd = ref_mem[a];
    end
    #1;
    check_val(tag, bus.read_data, ref_rd);
    #3;
    check_val({tag, "_hold"}, bus.read_data, ref_rd);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          rr;
    logic          rw;

    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.addr         = '0;
    bus.write_data   = '0;
    ref_rd           = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // reset held for two edges, then idle reads of addr 1
    do_cycle(1'b1, 1'b0, 10'd1, 8'h00, "rst0");
    do_cycle(1'b1, 1'b0, 10'd1, 8'h00, "rst1");
    check_val("rst_const", bus.read_data, 8'h00);
    do_cycle(1'b0, 1'b0, 10'd1, 8'h00, "post_rst0");
    do_cycle(1'b0, 1'b0, 10'd1, 8'h00, "post_rst1");

    // basic write with forwarding, then hold reads
    do_cycle(1'b0, 1'b1, 10'd1, 8'h04, "wr_fwd");
    check_val("wr_fwd_const", bus.read_data, 8'h04);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 10'd1, 8'h00, "rd_hold");

    // address isolation including both ends of the range
    do_cycle(1'b0, 1'b1, 10'd0,    8'hA5, "iso_w0");
    do_cycle(1'b0, 1'b1, 10'd1023, 8'h3C, "iso_w1023");
    do_cycle(1'b0, 1'b1, 10'd1,    8'h04, "iso_w1");
    do_cycle(1'b0, 1'b0, 10'd0,    8'h00, "iso_r0");
    check_val("iso_r0_const", bus.read_data, 8'hA5);
    do_cycle(1'b0, 1'b0, 10'd1023, 8'h00, "iso_r1023");
    check_val("iso_r1023_const", bus.read_data, 8'h3C);
    do_cycle(1'b0, 1'b0, 10'd1,    8'h00, "iso_r1");
    do_cycle(1'b0, 1'b0, 10'd2,    8'h00, "iso_r2");
    check_val("iso_r2_const", bus.read_data, 8'h00);

    // overwrite
    do_cycle(1'b0, 1'b1, 10'd5, 8'h11, "ovw_a");
    do_cycle(1'b0, 1'b1, 10'd5, 8'h22, "ovw_b");
    do_cycle(1'b0, 1'b0, 10'd9, 8'h00, "ovw_other");
    do_cycle(1'b0, 1'b0, 10'd5, 8'h00, "ovw_rd");
    check_val("ovw_rd_const", bus.read_data, 8'h22);

    // reset beats a concurrent write; everything reads back zero
    do_cycle(1'b1, 1'b1, 10'd7, 8'hFF, "mid_rst");
    do_cycle(1'b0, 1'b0, 10'd0,    8'h00, "mid_r0");
    do_cycle(1'b0, 1'b0, 10'd1,    8'h00, "mid_r1");
    do_cycle(1'b0, 1'b0, 10'd7,    8'h00, "mid_r7");
    check_val("mid_r7_const", bus.read_data, 8'h00);
    do_cycle(1'b0, 1'b0, 10'd1023, 8'h00, "mid_r1023");

    // back-to-back write/read alternation
    for (int n = 1; n <= 16; n++) begin
      do_cycle(1'b0, 1'b1, AW'(n), DW'(n), "alt_w");
      do_cycle(1'b0, 1'b0, AW'(n - 1), 8'h00, "alt_r");
      check_val("alt_r_const", bus.read_data, DW'(n - 1));
    end

    // random traffic over a small address pool plus the range ends to force reuse
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = AW'(DEPTH - 1);
        default: ra = AW'($urandom_range(0, 31));
      endcase
      rr = ($urandom_range(0, 199) == 0);
      rw = ($urandom_range(0, 1) == 1);
      do_cycle(rr, rw, ra, DW'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
